// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch sequencer. Owns the PC, issues one
//            instruction-memory request at a time, buffers the returned word
//            and hands it to decode over valid/ready. Redirects squash any
//            in-flight or buffered fetch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [63:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state_q;
   logic [63:0] pc_q;
   logic        squash_q;
   logic [31:0] instr_q;
   logic [63:0] instr_pc_q;
   logic [63:0] fetch_count_q;

   // Redirect targets are always forced onto a 4-byte boundary.
   logic [63:0] redirect_tgt;
   assign redirect_tgt = redirect_pc & ~64'd3;

   // Fetch FSM: redirect has priority in every state; squash marks an
   // outstanding response whose word must be discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         squash_q      <= 1'b0;
         instr_q       <= 32'd0;
         instr_pc_q    <= 64'd0;
         fetch_count_q <= 64'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_REQ;
            end
            S_REQ: begin
               if (redirect_valid) begin
                  pc_q <= redirect_tgt;
                  if (imem_req_ready) begin
                     // Old-pc request was accepted; its response is stale.
                     squash_q <= 1'b1;
                     state_q  <= S_WAIT;
                  end
               end else if (imem_req_ready) begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc_q <= redirect_tgt;
                  if (imem_resp_valid) begin
                     squash_q <= 1'b0;
                     state_q  <= S_REQ;
                  end else begin
                     squash_q <= 1'b1;
                  end
               end else if (imem_resp_valid) begin
                  if (squash_q) begin
                     // pc already holds the redirect target.
                     squash_q <= 1'b0;
                     state_q  <= S_REQ;
                  end else begin
                     instr_q    <= imem_resp_data;
                     instr_pc_q <= pc_q;
                     pc_q       <= pc_q + 64'd4;
                     state_q    <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  // Buffered word is abandoned, not counted as delivered.
                  pc_q    <= redirect_tgt;
                  state_q <= S_REQ;
               end else if (instr_ready) begin
                  fetch_count_q <= fetch_count_q + 64'd1;
                  state_q       <= S_REQ;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign instr_valid    = (state_q == S_HOLD);
   assign instr          = instr_q;
   assign instr_pc       = instr_pc_q;
   assign fetch_count    = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Self-checking bench for fetch_sequencer. Delivered words are
//            pushed to a scoreboard queue when the memory response is driven
//            and popped when decode sees them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

   localparam logic [63:0] C_RESET_PC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        instr_ready;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [63:0] fetch_count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [95:0] sb_q[$];
   logic [63:0] exp_pc;
   logic [63:0] exp_count;

   fetch_sequencer #(.RESET_PC(C_RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_ready     (instr_ready),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .fetch_count     (fetch_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Wait (bounded) for a request, hold it off rdy_delay cycles, then accept.
   task automatic issue(input int rdy_delay);
      int t = 0;
      while (!imem_req_valid && t < 10) begin
         @(negedge clk);
         t++;
      end
      chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("req_addr", imem_req_addr, exp_pc);
      for (int i = 0; i < rdy_delay; i++) begin
         @(negedge clk);
         chk("stall_valid", {63'd0, imem_req_valid}, 64'd1);
         chk("stall_addr", imem_req_addr, exp_pc);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
   endtask

   task automatic fetch_one(input logic [31:0] data, input int rdy_delay, input int resp_delay,
                            input int hold_cyc, input bit redir_hold, input logic [63:0] tgt);
      logic [95:0] e;
      issue(rdy_delay);
      for (int i = 1; i < resp_delay; i++) begin
         @(negedge clk);
         chk("wait_no_instr", {63'd0, instr_valid}, 64'd0);
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      sb_q.push_back({exp_pc, data});
      exp_pc = exp_pc + 64'd4;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      chk("instr_valid", {63'd0, instr_valid}, 64'd1);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd1, 64'd0);
         e = '0;
      end else begin
         e = sb_q.pop_front();
      end
      chk("instr", {32'd0, instr}, {32'd0, e[31:0]});
      chk("instr_pc", instr_pc, e[95:32]);
      for (int i = 0; i < hold_cyc; i++) begin
         @(negedge clk);
         chk("bp_valid", {63'd0, instr_valid}, 64'd1);
         chk("bp_instr", {32'd0, instr}, {32'd0, e[31:0]});
         chk("bp_pc", instr_pc, e[95:32]);
         chk("bp_no_req", {63'd0, imem_req_valid}, 64'd0);
         chk("bp_count", fetch_count, exp_count);
      end
      instr_ready = 1'b1;
      if (redir_hold) begin
         redirect_valid = 1'b1;
         redirect_pc    = tgt;
         exp_pc         = tgt & ~64'd3;
      end else begin
         exp_count = exp_count + 64'd1;
      end
      @(negedge clk);
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      chk("post_valid", {63'd0, instr_valid}, 64'd0);
      chk("post_count", fetch_count, exp_count);
      chk("next_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("next_req_addr", imem_req_addr, exp_pc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
      instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      exp_pc = C_RESET_PC; exp_count = 64'd0;
      repeat (3) @(negedge clk);
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rst_req_addr", imem_req_addr, C_RESET_PC);
      chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("rst_count", fetch_count, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      // Cycle 1 after release: request at RESET_PC; word visible on cycle 3.
      chk("c1_req_valid", {63'd0, imem_req_valid}, 64'd1);
      fetch_one(32'h0000_0013, 0, 1, 0, 1'b0, 64'd0);

      // Decode back-pressure for 5 cycles, then memory stall for 3 cycles.
      fetch_one(32'h0010_0093, 0, 1, 5, 1'b0, 64'd0);
      fetch_one(32'h0020_0113, 3, 2, 0, 1'b0, 64'd0);

      // Redirect during WAIT; stale response arrives two cycles later.
      issue(0);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rw_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("rw_no_instr", {63'd0, instr_valid}, 64'd0);
      @(negedge clk);
      imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      chk("rw_drop", {63'd0, instr_valid}, 64'd0);
      exp_pc = 64'h8000_1000;
      fetch_one(32'h0030_0193, 0, 1, 0, 1'b0, 64'd0);

      // Redirect coincident with the response.
      issue(0);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_2003;
      imem_resp_valid = 1'b1; imem_resp_data = 32'hbad0_bad0;
      @(negedge clk);
      redirect_valid = 1'b0; imem_resp_valid = 1'b0;
      chk("rr_drop", {63'd0, instr_valid}, 64'd0);
      exp_pc = 64'h8000_2000;
      fetch_one(32'h0040_0213, 0, 1, 0, 1'b0, 64'd0);

      // Redirect coincident with request acceptance.
      while (!imem_req_valid) @(negedge clk);
      imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h9000;
      @(negedge clk);
      imem_req_ready = 1'b0; redirect_valid = 1'b0;
      chk("ra_no_req", {63'd0, imem_req_valid}, 64'd0);
      imem_resp_valid = 1'b1; imem_resp_data = 32'hcafe_f00d;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      chk("ra_drop", {63'd0, instr_valid}, 64'd0);
      exp_pc = 64'h9000;
      fetch_one(32'h0050_0293, 0, 1, 0, 1'b0, 64'd0);

      // Redirect while holding a word, with decode ready.
      fetch_one(32'h0060_0313, 0, 1, 0, 1'b1, 64'h100);
      fetch_one(32'h0070_0393, 0, 3, 1, 1'b0, 64'd0);

      // Reset while waiting for a response; a late response is ignored.
      issue(0);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("mr_req_addr", imem_req_addr, C_RESET_PC);
      chk("mr_instr_valid", {63'd0, instr_valid}, 64'd0);
      chk("mr_instr", {32'd0, instr}, 64'd0);
      chk("mr_instr_pc", instr_pc, 64'd0);
      chk("mr_count", fetch_count, 64'd0);
      rst = 1'b0;
      imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      chk("mr_ignore", {63'd0, instr_valid}, 64'd0);
      exp_pc = C_RESET_PC; exp_count = 64'd0; sb_q.delete();
      fetch_one(32'h0080_0413, 0, 1, 0, 1'b0, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
